// File: rtl/rule110_host_seq.sv
// Host-side sequencer for the Rule 110 cell array: loads blocks, runs
// N generations and dumps every block back out through a byte stream.
module rule110_host_seq #(
   parameter int NUM_BLOCKS = 30,
   parameter int ADDR_W     = 6,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CNT_W-1:0]  cmd_count,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [7:0]        rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              dev_we_n,
   output logic              dev_halt_n,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [7:0]        dev_wdata,
   input  logic [7:0]        dev_rdata,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on any rising clk edge where valid and
   // ready are both high; a valid source holds its payload until it transfers.

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_DUMP_ADDR, S_DUMP_SAMPLE, S_DUMP_OUT
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'd1;
   localparam logic [1:0] OP_RUN  = 2'd2;
   localparam logic [1:0] OP_DUMP = 2'd3;
   localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);

   state_t             state_q;
   logic [ADDR_W-1:0]  blk_q;
   logic [CNT_W-1:0]   gen_q;
   logic               cmd_ready_q, wr_ready_q, rd_valid_q, rd_last_q, busy_q;
   logic               dev_we_n_q, dev_halt_n_q;
   logic [ADDR_W-1:0]  dev_addr_q;
   logic [7:0]         dev_wdata_q, rd_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         blk_q        <= '0;
         gen_q        <= '0;
         cmd_ready_q  <= 1'b1;
         wr_ready_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_data_q    <= '0;
         busy_q       <= 1'b0;
         dev_we_n_q   <= 1'b1;
         dev_halt_n_q <= 1'b0;
         dev_addr_q   <= '0;
         dev_wdata_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  blk_q      <= '0;
                  dev_addr_q <= '0;
                  case (cmd_op)
                     OP_LOAD: begin
                        state_q     <= S_LOAD;
                        wr_ready_q  <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                     end
                     OP_DUMP: begin
                        state_q     <= S_DUMP_ADDR;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                     end
                     OP_RUN: begin
                        if (cmd_count != '0) begin
                           state_q      <= S_RUN;
                           gen_q        <= cmd_count;
                           dev_halt_n_q <= 1'b1;
                           cmd_ready_q  <= 1'b0;
                           busy_q       <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_LOAD: begin
               dev_we_n_q <= 1'b1;
               // wr_ready already dropped: this cycle carries the final write
               if (!wr_ready_q) begin
                  state_q     <= S_IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (wr_valid) begin
                  dev_we_n_q  <= 1'b0;
                  dev_addr_q  <= blk_q;
                  dev_wdata_q <= wr_data;
                  if (blk_q == LAST_BLK) wr_ready_q <= 1'b0;
                  else                   blk_q      <= blk_q + ADDR_W'(1);
               end
            end
            S_RUN: begin
               if (gen_q == CNT_W'(1)) begin
                  dev_halt_n_q <= 1'b0;
                  state_q      <= S_IDLE;
                  cmd_ready_q  <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  gen_q <= gen_q - CNT_W'(1);
               end
            end
            S_DUMP_ADDR: begin
               // array output is combinational from the address: settle one cycle
               dev_addr_q <= blk_q;
               state_q    <= S_DUMP_SAMPLE;
            end
            S_DUMP_SAMPLE: begin
               rd_data_q  <= dev_rdata;
               rd_valid_q <= 1'b1;
               rd_last_q  <= (blk_q == LAST_BLK);
               state_q    <= S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
               if (rd_ready) begin
                  rd_valid_q <= 1'b0;
                  rd_last_q  <= 1'b0;
                  if (rd_last_q) begin
                     state_q     <= S_IDLE;
                     cmd_ready_q <= 1'b1;
                     busy_q      <= 1'b0;
                  end else begin
                     blk_q   <= blk_q + ADDR_W'(1);
                     state_q <= S_DUMP_ADDR;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign wr_ready   = wr_ready_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_last    = rd_last_q;
   assign busy       = busy_q;
   assign dev_we_n   = dev_we_n_q;
   assign dev_halt_n = dev_halt_n_q;
   assign dev_addr   = dev_addr_q;
   assign dev_wdata  = dev_wdata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_rule110_host_seq.sv
// Directed bench for rule110_host_seq with a 3-block array whose data
// outputs read back as 0x10 + address.
module tb_rule110_host_seq;

  localparam int NB = 3;
  localparam int AW = 6;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          wr_valid, wr_ready;
  logic [7:0]    wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [7:0]    rd_data;
  logic          busy, dev_we_n, dev_halt_n;
  logic [AW-1:0] dev_addr;
  logic [7:0]    dev_wdata, dev_rdata;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  rule110_host_seq #(.NUM_BLOCKS(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .dev_we_n(dev_we_n), .dev_halt_n(dev_halt_n),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_rdata(dev_rdata),
    .dbg_state(dbg_state)
  );

  // array read model
  assign dev_rdata = 8'h10 + {2'b00, dev_addr};

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // advance one cycle; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [CW-1:0] cnt);
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_count = '0;
  endtask

  task automatic test_reset();
    // {halt_n, we_n, rd_valid, cmd_ready, busy, wr_ready, rd_last}
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    checks++;
    if ({dev_halt_n, dev_we_n, rd_valid, cmd_ready, busy, wr_ready, rd_last} !== 7'b0101000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0101000",
               {dev_halt_n, dev_we_n, rd_valid, cmd_ready, busy, wr_ready, rd_last});
    end
    checks++;
    if ({dev_addr, dev_wdata, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h wdata=%h rd_data=%h want 0", dev_addr, dev_wdata, rd_data);
    end
    // reset in the middle of a long RUN
    send_cmd(2'd2, 16'd100);
    step();
    step();
    checks++;
    if (dev_halt_n !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL run_active halt_n=%b busy=%b want 1 1", dev_halt_n, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({dev_halt_n, dev_we_n, rd_valid, cmd_ready, busy} !== 5'b01010 || dev_addr !== '0) begin
      errors++;
      $display("FAIL reset_mid_run flags=%b addr=%h want 01010 0",
               {dev_halt_n, dev_we_n, rd_valid, cmd_ready, busy}, dev_addr);
    end
    step();
  endtask

  task automatic test_load_back_to_back();
    logic [7:0] d[3] = '{8'h07, 8'hE6, 8'hD7};
    send_cmd(2'd1, '0);
    checks++;
    if (wr_ready !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_enter wr_ready=%b busy=%b cmd_ready=%b want 1 1 0", wr_ready, busy, cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = d[i];
      step();
      checks++;
      if (dev_we_n !== 1'b0 || dev_addr !== AW'(i) || dev_wdata !== d[i] || wr_ready !== (i < 2)) begin
        errors++;
        $display("FAIL load_b2b_%0d we_n=%b addr=%0d wdata=%h wr_ready=%b want 0 %0d %h %b",
                 i, dev_we_n, dev_addr, dev_wdata, wr_ready, i, d[i], (i < 2));
      end
    end
    wr_valid = 1'b0;
    step();
    checks++;
    if (dev_we_n !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_b2b_done we_n=%b busy=%b cmd_ready=%b wr_ready=%b want 1 0 1 0",
               dev_we_n, busy, cmd_ready, wr_ready);
    end
  endtask

  task automatic test_load_gapped();
    logic [7:0] d[3] = '{8'h5A, 8'h00, 8'hFF};
    send_cmd(2'd1, '0);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = d[i];
      step();
      checks++;
      if (dev_we_n !== 1'b0 || dev_addr !== AW'(i) || dev_wdata !== d[i]) begin
        errors++;
        $display("FAIL load_gap_wr_%0d we_n=%b addr=%0d wdata=%h want 0 %0d %h",
                 i, dev_we_n, dev_addr, dev_wdata, i, d[i]);
      end
      wr_valid = 1'b0;
      wr_data  = 8'hAA;
      step();
      checks++;
      if (dev_we_n !== 1'b1) begin
        errors++;
        $display("FAIL load_gap_idle_%0d we_n=%b want 1", i, dev_we_n);
      end
    end
    // wr_valid outside LOAD has no effect
    wr_valid = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (dev_we_n !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL wr_outside_load we_n=%b wr_ready=%b busy=%b want 1 0 0", dev_we_n, wr_ready, busy);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_run();
    logic [19:0] halt_seen;
    logic        we_bad;
    halt_seen = '0;
    we_bad    = 1'b0;
    send_cmd(2'd2, 16'd5);
    for (int j = 0; j < 20; j++) begin
      halt_seen[j] = dev_halt_n;
      if (dev_we_n !== 1'b1) we_bad = 1'b1;
      step();
    end
    checks++;
    if (halt_seen !== 20'h0001F) begin
      errors++;
      $display("FAIL run5_halt_pattern got %h want 0001f", halt_seen);
    end
    checks++;
    if (we_bad !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL run5_we_cmd we_bad=%b cmd_ready=%b want 0 1", we_bad, cmd_ready);
    end
    // zero-count RUN is accepted and does nothing
    halt_seen = '0;
    send_cmd(2'd2, 16'd0);
    for (int j = 0; j < 6; j++) begin
      halt_seen[j] = dev_halt_n;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL run0_idle_%0d cmd_ready=%b busy=%b want 1 0", j, cmd_ready, busy);
      end
      step();
    end
    checks++;
    if (halt_seen !== '0) begin
      errors++;
      $display("FAIL run0_halt got %h want 0", halt_seen);
    end
  endtask

  task automatic test_dump();
    logic [7:0] exp;
    logic       halt_bad;
    int         waited;
    halt_bad = 1'b0;
    exp_q    = '{8'h10, 8'h11, 8'h12};
    rd_ready = 1'b0;
    send_cmd(2'd3, '0);
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dump_busy cmd_ready=%b busy=%b want 0 1", cmd_ready, busy);
    end
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      waited = 0;
      while (rd_valid !== 1'b1 && waited < 10) begin
        if (dev_halt_n !== 1'b0) halt_bad = 1'b1;
        step();
        waited++;
      end
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (exp == 8'h12)) begin
        errors++;
        $display("FAIL dump_byte valid=%b data=%h last=%b want 1 %h %b",
                 rd_valid, rd_data, rd_last, exp, (exp == 8'h12));
      end
      for (int k = 0; k < 4; k++) begin
        step();
        if (dev_halt_n !== 1'b0) halt_bad = 1'b1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || rd_last !== (exp == 8'h12)) begin
          errors++;
          $display("FAIL dump_hold_%0d valid=%b data=%h last=%b want 1 %h %b",
                   k, rd_valid, rd_data, rd_last, exp, (exp == 8'h12));
        end
      end
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      checks++;
      if (rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL dump_release valid=%b want 0", rd_valid);
      end
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || halt_bad !== 1'b0) begin
      errors++;
      $display("FAIL dump_done cmd_ready=%b busy=%b halt_bad=%b want 1 0 0", cmd_ready, busy, halt_bad);
    end
  endtask

  task automatic test_reset_mid_dump();
    int waited;
    rd_ready = 1'b0;
    send_cmd(2'd3, '0);
    waited = 0;
    while (rd_valid !== 1'b1 && waited < 10) begin
      step();
      waited++;
    end
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL dump2_valid got %b want 1", rd_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({rd_valid, rd_last, cmd_ready, busy, dev_halt_n} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_mid_dump flags=%b want 00100", {rd_valid, rd_last, cmd_ready, busy, dev_halt_n});
    end
    step();
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_count = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    rd_ready  = 1'b0;
    test_reset();
    test_load_back_to_back();
    test_load_gapped();
    test_run();
    test_dump();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rule110_host_seq.md
Name: rule110_host_seq

Overview:
- Host-side sequencer that drives the block-addressed pin interface of the Rule 110 cell array from the other end.
- Accepts commands on a valid/ready port:
  - LOAD: stream NUM_BLOCKS bytes into the array.
  - RUN: release halt for N generations.
  - DUMP: read every block back and stream it out.
- Sits in the FPGA/host test harness; the dev_* pins connect directly to the array's data_in, data_out and control/address pins.

Parameters:
- NUM_BLOCKS, 30, number of 8-cell blocks addressed (1..62; the all-ones address is never issued).
- ADDR_W, 6, width of dev_addr.
- CNT_W, 16, width of the RUN generation count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=NOP, 1=LOAD, 2=RUN, 3=DUMP
- cmd_count  in  CNT_W  generations for RUN; ignored otherwise
- wr_valid  in  1  load byte offered
- wr_ready  out  1  load byte accepted when both high
- wr_data  in  8  load byte (bit0 = lowest cell of block)
- rd_valid  out  1  dump byte available
- rd_ready  in  1  downstream accepts dump byte
- rd_data  out  8  dump byte
- rd_last  out  1  high with the byte for block NUM_BLOCKS-1
- busy  out  1  state != IDLE
- dev_we_n  out  1  active-low write strobe to the array
- dev_halt_n  out  1  active-low halt to the array
- dev_addr  out  ADDR_W  block address to the array
- dev_wdata  out  8  data to the array's data inputs
- dev_rdata  in  8  data from the array's data outputs

Behaviour:

Reset values and output rules
- All outputs are registered.
- Reset values: dev_we_n=1, dev_halt_n=0, dev_addr=0, dev_wdata=0, rd_valid=0, rd_last=0, rd_data=0, wr_ready=0, busy=0.
- Reset applies in any state: it aborts the current operation immediately and returns to IDLE. A partially loaded array is left as-is; no further strobes are issued.
- dev_halt_n is 0 in every state except RUN.
- dev_we_n is 0 only on LOAD write cycles.

States: IDLE, LOAD, RUN, DUMP_ADDR, DUMP_SAMPLE, DUMP_OUT.

IDLE
- cmd_ready=1.
- On cmd_valid, take the command: blk<=0, dev_addr<=0.
- Next state by op:
  - LOAD -> LOAD.
  - DUMP -> DUMP_ADDR.
  - RUN with count>0 -> RUN, gen<=count.
  - RUN with count=0 -> stays IDLE (accepted, no action).
  - NOP -> stays IDLE (accepted, no action).

LOAD
- wr_ready=1.
- Each accepted byte (handshake at cycle t) drives, in cycle t+1: dev_we_n=0, dev_addr=blk, dev_wdata=wr_data. blk then increments.
- Back-to-back accepts give one write per cycle.
- A cycle without an accept drives dev_we_n=1.
- On accepting the byte for blk=NUM_BLOCKS-1:
  - wr_ready drops in t+1.
  - The write cycle completes in t+1.
  - The state is IDLE from t+2.

RUN
- dev_halt_n=1 and dev_we_n=1 for exactly cmd_count consecutive cycles, i.e. cmd_count generations.
- gen decrements each cycle. When gen reaches 1, the next cycle has dev_halt_n=0 and the state is IDLE.

DUMP_ADDR
- dev_addr<=blk, then -> DUMP_SAMPLE.
- This gives one settle cycle, because the array output is combinational from the address.

DUMP_SAMPLE
- rd_data<=dev_rdata, rd_valid<=1, rd_last<=(blk==NUM_BLOCKS-1), then -> DUMP_OUT.

DUMP_OUT
- rd_data, rd_valid and rd_last hold stable until rd_ready.
- On handshake, rd_valid<=0.
  - If last: -> IDLE.
  - Otherwise: blk++ and -> DUMP_ADDR.
- Peak throughput is one byte per 3 cycles.
- The array stays halted throughout, so all blocks belong to the same generation.

Boundary conditions
- Commands arriving while busy are not accepted (cmd_ready=0).
- wr_valid outside LOAD is ignored.
- The blk counter never exceeds NUM_BLOCKS-1.
- The address width is sized so that dev_addr never equals all-ones.

Test Plan:
1. Reset during arbitrary activity -> next cycle: dev_halt_n=0, dev_we_n=1, dev_addr=0, rd_valid=0, cmd_ready=1, busy=0.
2. NUM_BLOCKS=3, LOAD with bytes 0x07, 0xE6, 0xD7 offered back-to-back:
   - Three consecutive cycles with dev_we_n=0, addr 0/1/2, matching data.
   - wr_ready low afterwards; IDLE two cycles after the last accept.
3. LOAD with wr_valid gapped (1 idle cycle between bytes) -> dev_we_n pulses once per byte, never during gaps; address still 0,1,2.
4. RUN cmd_count=5 -> dev_halt_n high for exactly 5 clocks, dev_we_n=1 throughout.
5. RUN cmd_count=0 -> dev_halt_n never rises; accepted; cmd_ready stays 1.
6. DUMP with rd_ready held low 4 cycles per byte, against a model returning 0x10+addr:
   - Bytes 0x10, 0x11, 0x12 in order, each stable while waiting.
   - rd_last only on 0x12.
   - dev_halt_n=0 throughout.
   - Reset mid-DUMP clears rd_valid next cycle.
